dmc_memory_responder: RTL and testbench

Memory-side responder for the direct-mapped cache controller: it answers the controller's block and line read/write requests against a parameterised backing store. It inserts a programmable access latency and streams line bursts one block per beat, returning a completion strobe. It sits between `DMC_Controller`'s memory port and the testbench or system, replacing a zero-latency memory so that fetch, flush and write-back paths are exercised with realistic wait states.

---
 rtl/dmc_memory_responder.sv | 124 ++++++++++++
 tb/tb_dmc_memory_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dmc_memory_responder.sv
// Memory-side responder for the direct-mapped cache controller: single-block and
// line-burst accesses against a local block store, with a programmable wait latency.
module dmc_memory_responder #(
  parameter int BLOCK_SIZE             = 4,
  parameter int NUM_OF_BLOCKS_PER_LINE = 2,
  parameter int ADDRESS_SIZE           = 16,
  parameter int MEM_DEPTH              = 256,
  parameter int LATENCY                = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    read_i,
  input  logic                    write_i,
  input  logic                    line_i,
  input  logic [ADDRESS_SIZE-1:0] address_i,
  input  logic [BLOCK_SIZE-1:0]   data_i,
  output logic [BLOCK_SIZE-1:0]   data_o,
  output logic                    beat_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o
);

  localparam int N   = NUM_OF_BLOCKS_PER_LINE;
  localparam int AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LCW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int BCW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDRESS_SIZE-1:0] LINE_MASK   = ~ADDRESS_SIZE'(N - 1);
  localparam logic [ADDRESS_SIZE:0]   DEPTH_LIMIT = (ADDRESS_SIZE + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  state_t          state_reg, state_next;
  logic [LCW-1:0]  lat_cnt_reg, lat_cnt_next;
  logic [BCW-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [AW-1:0]   start_reg, start_next;
  logic            line_reg, line_next;
  logic            write_reg, write_next;
  logic            error_reg, error_next;

  logic [BLOCK_SIZE-1:0] mem [MEM_DEPTH];

  logic [ADDRESS_SIZE-1:0] req_start;
  logic [ADDRESS_SIZE:0]   req_last;
  logic                    req_illegal;
  logic [AW-1:0]           beat_idx;
  logic [BCW-1:0]          last_beat;

  // The whole burst range is checked up front so an illegal burst never touches memory.
  assign req_start   = line_i ? (address_i & LINE_MASK) : address_i;
  assign req_last    = {1'b0, req_start} + (line_i ? (ADDRESS_SIZE + 1)'(N - 1) : '0);
  assign req_illegal = (read_i & write_i) | (req_last >= DEPTH_LIMIT);

  assign beat_idx  = start_reg + AW'(beat_cnt_reg);
  assign last_beat = line_reg ? BCW'(N - 1) : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      lat_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
      start_reg    <= '0;
      line_reg     <= 1'b0;
      write_reg    <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lat_cnt_reg  <= lat_cnt_next;
      beat_cnt_reg <= beat_cnt_next;
      start_reg    <= start_next;
      line_reg     <= line_next;
      write_reg    <= write_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lat_cnt_next  = lat_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    start_next    = start_reg;
    line_next     = line_reg;
    write_next    = write_reg;
    error_next    = error_reg;
    unique case (state_reg)
      // DONE is not busy, so it accepts a new request exactly like IDLE.
      IDLE, DONE: begin
        state_next = IDLE;
        if (read_i | write_i) begin
          write_next    = write_i;
          line_next     = line_i;
          start_next    = req_start[AW-1:0];
          beat_cnt_next = '0;
          lat_cnt_next  = LCW'(LATENCY);
          error_next    = req_illegal;
          if (req_illegal)       state_next = DONE;
          else if (LATENCY == 0) state_next = XFER;
          else                   state_next = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_next = lat_cnt_reg - 1'b1;
        if (lat_cnt_reg == LCW'(1)) state_next = XFER;
      end
      XFER: begin
        if (beat_cnt_reg == last_beat) state_next = DONE;
        else                           beat_cnt_next = beat_cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory is deliberately left out of reset; contents survive an aborted request.
  always_ff @(posedge clk_i) begin
    if (state_reg == XFER && write_reg) mem[beat_idx] <= data_i;
  end

  assign beat_o  = (state_reg == XFER);
  assign busy_o  = (state_reg == WAIT) || (state_reg == XFER);
  assign done_o  = (state_reg == DONE);
  assign error_o = (state_reg == DONE) && error_reg;
  assign data_o  = (state_reg == XFER && !write_reg) ? mem[beat_idx] : '0;

endmodule

// File: tb/tb_dmc_memory_responder.sv
// Directed bench for dmc_memory_responder: one instance with LATENCY=3 and one
// with LATENCY=0, checked cycle by cycle against hand-computed beat/done timing.
module tb_dmc_memory_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]       rd, wr, ln;
  logic [1:0][15:0] addr;
  logic [1:0][3:0]  wdata;
  wire  [1:0][3:0]  rdata;
  wire  [1:0]       beat, busy, done, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmc_memory_responder #(.LATENCY(3)) u_dut_lat3 (
    .clk_i(clk), .rst_n_i(rst_n), .read_i(rd[0]), .write_i(wr[0]), .line_i(ln[0]),
    .address_i(addr[0]), .data_i(wdata[0]), .data_o(rdata[0]), .beat_o(beat[0]),
    .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0])
  );

  dmc_memory_responder #(.LATENCY(0)) u_dut_lat0 (
    .clk_i(clk), .rst_n_i(rst_n), .read_i(rd[1]), .write_i(wr[1]), .line_i(ln[1]),
    .address_i(addr[1]), .data_i(wdata[1]), .data_o(rdata[1]), .beat_o(beat[1]),
    .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input int sel, input string ctx);
    check($sformatf("%s dut%0d busy", ctx, sel), 16'(busy[sel]), 16'd0);
    check($sformatf("%s dut%0d beat", ctx, sel), 16'(beat[sel]), 16'd0);
    check($sformatf("%s dut%0d done", ctx, sel), 16'(done[sel]), 16'd0);
    check($sformatf("%s dut%0d error", ctx, sel), 16'(err[sel]), 16'd0);
    check($sformatf("%s dut%0d data", ctx, sel), 16'(rdata[sel]), 16'd0);
  endtask

  // Called at a negedge; request is accepted at the next posedge and the task
  // returns at the negedge of the DONE cycle, so calls chain back-to-back.
  task automatic do_req(input int sel, input logic r, input logic w, input logic l,
                        input logic [15:0] a, input logic [3:0] d0, input logic [3:0] d1,
                        input bit bad);
    int lat, n, last;
    logic [3:0] dv;
    bit exp_beat;
    lat  = (sel == 0) ? 3 : 0;
    n    = l ? 2 : 1;
    last = bad ? 0 : lat + n;
    rd[sel] = r; wr[sel] = w; ln[sel] = l; addr[sel] = a;
    @(posedge clk);
    #1;
    rd[sel] = 1'b0; wr[sel] = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      exp_beat = !bad && (c >= lat) && (c < lat + n);
      dv = (c == lat) ? d0 : d1;
      wdata[sel] = (exp_beat && w) ? dv : 4'h0;
      check($sformatf("beat dut%0d a=%0d c=%0d", sel, a, c), 16'(beat[sel]), 16'(exp_beat));
      check($sformatf("busy dut%0d a=%0d c=%0d", sel, a, c), 16'(busy[sel]),
            16'(!bad && c < lat + n));
      check($sformatf("done dut%0d a=%0d c=%0d", sel, a, c), 16'(done[sel]), 16'(c == last));
      check($sformatf("error dut%0d a=%0d c=%0d", sel, a, c), 16'(err[sel]),
            16'(bad && c == last));
      if (r && !w)
        check($sformatf("data dut%0d a=%0d c=%0d", sel, a, c), 16'(rdata[sel]),
              exp_beat ? 16'(dv) : 16'd0);
    end
    $display("txn dut=%0d rd=%0b wr=%0b line=%0b addr=%0d illegal=%0b checks=%0d failures=%0d",
             sel, r, w, l, a, bad, checks, failures);
  endtask

  initial begin
    rst_n = 1'b0;
    rd = '0; wr = '0; ln = '0; addr = '0; wdata = '0;
    #2;
    check_idle_outputs(0, "reset");
    check_idle_outputs(1, "reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // LATENCY=3: preload, then reads, line burst, line write, illegal requests
    for (int i = 0; i < 16; i++) do_req(0, 1'b0, 1'b1, 1'b0, 16'(i), 4'(i), 4'h0, 1'b0);
    do_req(0, 1'b1, 1'b0, 1'b0, 16'd5,   4'd5, 4'd0, 1'b0);
    do_req(0, 1'b1, 1'b0, 1'b1, 16'd7,   4'd6, 4'd7, 1'b0);
    do_req(0, 1'b0, 1'b1, 1'b1, 16'd8,   4'hA, 4'hB, 1'b0);
    do_req(0, 1'b1, 1'b0, 1'b1, 16'd9,   4'hA, 4'hB, 1'b0);
    do_req(0, 1'b1, 1'b0, 1'b0, 16'd10,  4'd10, 4'd0, 1'b0);
    do_req(0, 1'b1, 1'b1, 1'b0, 16'd4,   4'hF, 4'h0, 1'b1);
    do_req(0, 1'b1, 1'b0, 1'b0, 16'd300, 4'd0, 4'd0, 1'b1);
    do_req(0, 1'b1, 1'b0, 1'b1, 16'd257, 4'd0, 4'd0, 1'b1);
    do_req(0, 1'b1, 1'b0, 1'b0, 16'd4,   4'd4, 4'd0, 1'b0);
    do_req(0, 1'b1, 1'b0, 1'b1, 16'd15,  4'd14, 4'd15, 1'b0);

    // LATENCY=0: back-to-back on the edge ending DONE
    for (int i = 0; i < 4; i++) do_req(1, 1'b0, 1'b1, 1'b0, 16'(i), 4'(i + 0), 4'h0, 1'b0);
    do_req(1, 1'b1, 1'b0, 1'b0, 16'd3, 4'd3, 4'd0, 1'b0);
    do_req(1, 1'b1, 1'b0, 1'b1, 16'd2, 4'd2, 4'd3, 1'b0);

    // Reset during WAIT of a line write to 12..13 aborts it asynchronously
    wr[0] = 1'b1; ln[0] = 1'b1; addr[0] = 16'd12; wdata[0] = 4'hE;
    @(posedge clk);
    #1;
    wr[0] = 1'b0;
    @(negedge clk);
    check("abort busy before reset", 16'(busy[0]), 16'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs(0, "abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn dut=0 reset abort of line write addr=12 checks=%0d failures=%0d", checks, failures);
    do_req(0, 1'b1, 1'b0, 1'b1, 16'd13, 4'd12, 4'd13, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
